if_id_buffer: RTL and testbench
===============================

# if_id_buffer

Two-entry instruction buffer forming the IF/ID boundary of the pipeline. Captures the fetched instruction, its PC and PC+4 from the fetch stage, and presents them to decode one cycle later. Decouples fetch from decode back-pressure through a valid/ready handshake. Discards all in-flight instructions when the execute stage resolves a taken jump or branch.

## Interface
- DEPTH, 2, number of buffer entries; power of two, minimum 2
- XLEN, 32, width of instruction and PC fields
- NOP_INST, 32'h00000013, value driven on ID_inst when no valid entry (addi x0,x0,0)

- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- IF_valid  in  1  fetch stage presents an instruction this cycle
- IF_inst  in  XLEN  fetched instruction
- IF_pc  in  XLEN  PC of fetched instruction
- IF_pc4  in  XLEN  PC+4 of fetched instruction
- IF_stall  out  1  buffer cannot accept; fetch holds PC (equals !in_ready)
- EX_jump  in  1  taken jump/branch resolved in EX; flush request
- ID_ready  in  1  decode consumes the head entry this cycle (low on load-use or other decode stall)
- ID_valid  out  1  head entry valid
- ID_inst  out  XLEN  head instruction, NOP_INST when ID_valid=0
- ID_pc  out  XLEN  head PC, 0 when ID_valid=0
- ID_pc4  out  XLEN  head PC+4, 0 when ID_valid=0

## Operation
- Circular buffer: storage arrays for inst/pc/pc4, write pointer wp, read pointer rp, occupancy count (0..DEPTH, width clog2(DEPTH)+1). Pointers wrap modulo DEPTH.
- push = IF_valid & !IF_stall & !EX_jump; pop = ID_valid & ID_ready & !EX_jump.
- IF_stall = (count == DEPTH). Registered-state only; no combinational path from ID_ready to IF_stall.
- push only: write at wp, wp++, count++. pop only: rp++, count--. push and pop together: write, both pointers advance, count unchanged (legal at any count < DEPTH).
- EX_jump: count, wp, rp to 0 next edge; overrides push and pop in the same cycle; the instruction presented by IF that cycle is dropped. EX_jump while empty is a no-op.
- ID_valid = (count != 0); outputs read combinationally from entry rp and masked to NOP_INST/0/0 when empty.
- Reset: count=0, wp=rp=0, ID_valid=0, ID_inst=NOP_INST, ID_pc=0, ID_pc4=0, IF_stall=0. Reset dominates EX_jump and all handshakes. Storage contents need not be cleared.
- Ordering strictly FIFO; no entry is duplicated or skipped across wrap-around.

## Timing
- Latency: instruction pushed at edge N is visible on ID_* after edge N (one cycle IF→ID) when buffer was empty.
- Throughput: 1 instruction/cycle sustained with ID_ready held high.
- Back-pressure: ID_ready low for k cycles with IF_valid high → buffer fills after DEPTH cycles; IF_stall asserts in the cycle count reaches DEPTH; with ID_ready high again, first pop occurs that cycle and IF_stall deasserts the following cycle.
- Flush: EX_jump high in cycle N → ID_valid=0 in cycle N+1; first post-jump instruction (IF_pc = EX_npc) pushed in N+1 appears on ID_* in N+2.
- Reset mid-operation: all entries lost; ID_valid=0 the cycle after rst sampled high.

## Structure
- Shared package pipe_pkg: XLEN, NOP_INST, and an if_id_t packed struct {inst, pc, pc4} reused by later stage registers.
- Single module; storage as an array of if_id_t. No sub-module required; pointer/count logic stays inline.

## Test plan
- Reset with IF_valid=1: after rst, ID_valid=0, ID_inst=32'h00000013, IF_stall=0; first push of pc=0x0 appears next cycle.
- Streaming: IF_valid=1, ID_ready=1, pc 0x00..0x1C → ID_pc sequence 0x00..0x1C one per cycle, one-cycle lag, no gaps.
- Back-pressure: ID_ready=0 for 4 cycles from empty → IF_stall high after 2 pushes (pc 0x00,0x04); release → ID_pc 0x00 then 0x04 then 0x08, no loss or duplicate across pointer wrap.
- Flush while full: count=2, EX_jump=1 with IF_valid=1, ID_ready=1 → next cycle ID_valid=0, count=0, no pop credited; next push pc=0x40 appears as first ID_pc.
- Simultaneous push/pop at count=1: ID_ready=1, IF_valid=1 → count stays 1, ID_pc advances by 4 each cycle.
- Reset mid-stream with count=2 and EX_jump=1 → all state cleared, ID_valid=0, IF_stall=0 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types: datapath width, the canonical NOP and the IF/ID payload.
// Later stage registers reuse if_id_t so the fetch payload layout lives in one place.
package pipe_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } if_id_t;

endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID buffer.
// The buffer is the slave; the fetch/decode stages (or a bench) drive the master side.
interface if_id_buffer_if;
    import pipe_pkg::*;

    logic            IF_valid;
    logic [XLEN-1:0] IF_inst;
    logic [XLEN-1:0] IF_pc;
    logic [XLEN-1:0] IF_pc4;
    logic            IF_stall;

    logic            ID_ready;
    logic            ID_valid;
    logic [XLEN-1:0] ID_inst;
    logic [XLEN-1:0] ID_pc;
    logic [XLEN-1:0] ID_pc4;

    modport slave (
        input  IF_valid, IF_inst, IF_pc, IF_pc4, ID_ready,
        output IF_stall, ID_valid, ID_inst, ID_pc, ID_pc4
    );

    modport master (
        output IF_valid, IF_inst, IF_pc, IF_pc4, ID_ready,
        input  IF_stall, ID_valid, ID_inst, ID_pc, ID_pc4
    );

endinterface

// File: rtl/if_id_buffer.sv
// Circular IF/ID instruction buffer: decouples fetch from decode stalls and
// drops everything in flight when EX resolves a taken jump/branch.
module if_id_buffer
    import pipe_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           EX_jump,
    if_id_buffer_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    if_id_t        mem_q [DEPTH];

    logic   push;
    logic   pop;
    logic   full;
    logic   head_valid;
    if_id_t head;

    // Stall depends on registered occupancy only, so ID_ready never reaches IF_stall.
    assign full       = (count_q == FULL);
    assign head_valid = (count_q != '0);

    always_comb begin
        push    = bus.IF_valid & ~full & ~EX_jump;
        pop     = head_valid & bus.ID_ready & ~EX_jump;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (EX_jump) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) wp_d = wp_q + 1'b1;
            if (pop)  rp_d = rp_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Payload storage is never cleared; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= '{inst: bus.IF_inst, pc: bus.IF_pc, pc4: bus.IF_pc4};
        end
    end

    assign head = mem_q[rp_q];

    assign bus.IF_stall = full;
    assign bus.ID_valid = head_valid;
    assign bus.ID_inst  = head_valid ? head.inst : NOP_INST;
    assign bus.ID_pc    = head_valid ? head.pc   : '0;
    assign bus.ID_pc4   = head_valid ? head.pc4  : '0;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: reset, streaming, back-pressure with wrap,
// flush, steady push/pop at one entry, and reset during activity.
module tb_if_id_buffer;
    import pipe_pkg::*;

    logic clk;
    logic rst;
    logic EX_jump;
    int   n_checks;
    int   n_fail;

    if_id_buffer_if bus ();

    if_id_buffer #(.DEPTH(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .EX_jump (EX_jump),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    task automatic set_if(input logic v, input logic [31:0] pc);
        bus.IF_valid = v;
        bus.IF_pc    = pc;
        bus.IF_pc4   = pc + 32'd4;
        bus.IF_inst  = mk_inst(pc);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        EX_jump = 1'b0;
        bus.ID_ready = 1'b0;
        set_if(1'b1, 32'h100);
        cyc();
        cyc();
        n_checks++;
        if (bus.ID_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.ID_valid); end
        n_checks++;
        if (bus.ID_inst !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_inst: got %h want 00000013", bus.ID_inst); end
        n_checks++;
        if (bus.ID_pc !== 32'h0 || bus.ID_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h/%h want 0/0", bus.ID_pc, bus.ID_pc4); end
        n_checks++;
        if (bus.IF_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", bus.IF_stall); end
        rst = 1'b0;
        set_if(1'b1, 32'h0);
        cyc();
        n_checks++;
        if (bus.ID_valid !== 1'b1 || bus.ID_pc !== 32'h0 || bus.ID_inst !== mk_inst(32'h0) || bus.ID_pc4 !== 32'h4) begin
            n_fail++; $display("FAIL reset_first_push: got v=%0b pc=%h inst=%h pc4=%h want v=1 pc=0 inst=%h pc4=4",
                               bus.ID_valid, bus.ID_pc, bus.ID_inst, bus.ID_pc4, mk_inst(32'h0));
        end
        set_if(1'b0, 32'h0);
        bus.ID_ready = 1'b1;
        cyc();
        n_checks++;
        if (bus.ID_valid !== 1'b0) begin n_fail++; $display("FAIL reset_drain: got %0b want 0", bus.ID_valid); end
    endtask

    task automatic test_streaming();
        bus.ID_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_if(1'b1, 32'(i * 4));
            cyc();
            n_checks++;
            if (bus.ID_valid !== 1'b1 || bus.ID_pc !== 32'(i * 4) || bus.ID_inst !== mk_inst(32'(i * 4)) || bus.IF_stall !== 1'b0) begin
                n_fail++; $display("FAIL stream_%0d: got v=%0b pc=%h inst=%h stall=%0b want v=1 pc=%h stall=0",
                                   i, bus.ID_valid, bus.ID_pc, bus.ID_inst, bus.IF_stall, 32'(i * 4));
            end
        end
        set_if(1'b0, 32'h0);
        cyc();
        n_checks++;
        if (bus.ID_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %0b want 0", bus.ID_valid); end
    endtask

    task automatic test_backpressure();
        logic        rdy   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        in_v  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] in_pc [7] = '{32'h00, 32'h04, 32'h08, 32'h08, 32'h08, 32'h08, 32'h00};
        logic        exp_v [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] exp_pc[7] = '{32'h00, 32'h00, 32'h00, 32'h00, 32'h04, 32'h08, 32'h00};
        logic        exp_st[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            bus.ID_ready = rdy[i];
            set_if(in_v[i], in_pc[i]);
            cyc();
            n_checks++;
            if (bus.ID_valid !== exp_v[i] || bus.ID_pc !== exp_pc[i] || bus.IF_stall !== exp_st[i]) begin
                n_fail++; $display("FAIL backpressure_%0d: got v=%0b pc=%h stall=%0b want v=%0b pc=%h stall=%0b",
                                   i, bus.ID_valid, bus.ID_pc, bus.IF_stall, exp_v[i], exp_pc[i], exp_st[i]);
            end
        end
    endtask

    task automatic test_flush();
        bus.ID_ready = 1'b0;
        set_if(1'b1, 32'h00);
        cyc();
        set_if(1'b1, 32'h04);
        cyc();
        n_checks++;
        if (bus.IF_stall !== 1'b1) begin n_fail++; $display("FAIL flush_fill: stall got %0b want 1", bus.IF_stall); end
        EX_jump = 1'b1;
        bus.ID_ready = 1'b1;
        set_if(1'b1, 32'h08);
        cyc();
        n_checks++;
        if (bus.ID_valid !== 1'b0 || bus.IF_stall !== 1'b0 || bus.ID_inst !== NOP_INST || bus.ID_pc !== 32'h0) begin
            n_fail++; $display("FAIL flush_clear: got v=%0b stall=%0b inst=%h pc=%h want v=0 stall=0 inst=00000013 pc=0",
                               bus.ID_valid, bus.IF_stall, bus.ID_inst, bus.ID_pc);
        end
        EX_jump = 1'b0;
        set_if(1'b1, 32'h40);
        cyc();
        n_checks++;
        if (bus.ID_valid !== 1'b1 || bus.ID_pc !== 32'h40 || bus.ID_pc4 !== 32'h44) begin
            n_fail++; $display("FAIL flush_first: got v=%0b pc=%h pc4=%h want v=1 pc=40 pc4=44", bus.ID_valid, bus.ID_pc, bus.ID_pc4);
        end
        set_if(1'b1, 32'h44);
        cyc();
        n_checks++;
        if (bus.ID_valid !== 1'b1 || bus.ID_pc !== 32'h44) begin
            n_fail++; $display("FAIL flush_second: got v=%0b pc=%h want v=1 pc=44", bus.ID_valid, bus.ID_pc);
        end
        set_if(1'b0, 32'h0);
        cyc();
        n_checks++;
        if (bus.ID_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drain: got %0b want 0", bus.ID_valid); end
        EX_jump = 1'b1;
        cyc();
        EX_jump = 1'b0;
        n_checks++;
        if (bus.ID_valid !== 1'b0 || bus.IF_stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_empty: got v=%0b stall=%0b want 0/0", bus.ID_valid, bus.IF_stall);
        end
    endtask

    task automatic test_push_pop_count1();
        bus.ID_ready = 1'b1;
        set_if(1'b1, 32'h80);
        cyc();
        n_checks++;
        if (bus.ID_pc !== 32'h80) begin n_fail++; $display("FAIL pp_prime: got pc=%h want 80", bus.ID_pc); end
        for (int i = 1; i <= 4; i++) begin
            set_if(1'b1, 32'h80 + 32'(i * 4));
            cyc();
            n_checks++;
            if (bus.ID_valid !== 1'b1 || bus.ID_pc !== 32'h80 + 32'(i * 4) || bus.IF_stall !== 1'b0) begin
                n_fail++; $display("FAIL pp_%0d: got v=%0b pc=%h stall=%0b want v=1 pc=%h stall=0",
                                   i, bus.ID_valid, bus.ID_pc, bus.IF_stall, 32'h80 + 32'(i * 4));
            end
        end
        set_if(1'b0, 32'h0);
        cyc();
        n_checks++;
        if (bus.ID_valid !== 1'b0) begin n_fail++; $display("FAIL pp_drain: got %0b want 0 (count not held at 1)", bus.ID_valid); end
    endtask

    task automatic test_reset_mid();
        bus.ID_ready = 1'b0;
        set_if(1'b1, 32'hB0);
        cyc();
        set_if(1'b1, 32'hB4);
        cyc();
        rst = 1'b1;
        EX_jump = 1'b1;
        bus.ID_ready = 1'b1;
        set_if(1'b1, 32'hB8);
        cyc();
        n_checks++;
        if (bus.ID_valid !== 1'b0 || bus.IF_stall !== 1'b0 || bus.ID_inst !== NOP_INST || bus.ID_pc4 !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid_clear: got v=%0b stall=%0b inst=%h pc4=%h want v=0 stall=0 inst=00000013 pc4=0",
                               bus.ID_valid, bus.IF_stall, bus.ID_inst, bus.ID_pc4);
        end
        rst = 1'b0;
        EX_jump = 1'b0;
        set_if(1'b1, 32'hC0);
        cyc();
        n_checks++;
        if (bus.ID_valid !== 1'b1 || bus.ID_pc !== 32'hC0 || bus.ID_inst !== mk_inst(32'hC0)) begin
            n_fail++; $display("FAIL reset_mid_restart: got v=%0b pc=%h inst=%h want v=1 pc=c0", bus.ID_valid, bus.ID_pc, bus.ID_inst);
        end
        set_if(1'b0, 32'h0);
        cyc();
        n_checks++;
        if (bus.ID_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_drain: got %0b want 0", bus.ID_valid); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        EX_jump  = 1'b0;
        bus.ID_ready = 1'b0;
        set_if(1'b0, 32'h0);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_push_pop_count1();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
